// File: rtl/reg64_pkg.sv
// reg64_pkg: shared constants and types for the 64-bit word serializer.
// Holds the default word width, the counter width derived from it, and the
// two-state FSM encoding used by the top level.
package reg64_pkg;

  localparam int REG64_WIDTH = 64;
  localparam int REG64_CNT_W = $clog2(REG64_WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/reg64_serializer_if.sv
// reg64_serializer_if: word-load and serial-bit handshakes of the serializer.
// Ports: load_data/load_valid/load_ready (parallel side), ser_out/ser_valid/
//        ser_ready/ser_last (serial side), busy (word in flight).
// master = the agent feeding words and sinking bits; slave = the serializer.
interface reg64_serializer_if
  import reg64_pkg::*;
#(
  parameter int WIDTH = REG64_WIDTH
);

  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_last;
  logic             busy;

  modport master (
    output load_data, load_valid, ser_ready,
    input  load_ready, ser_out, ser_valid, ser_last, busy
  );

  modport slave (
    input  load_data, load_valid, ser_ready,
    output load_ready, ser_out, ser_valid, ser_last, busy
  );

endinterface

// File: rtl/reg64_shift_reg.sv
// reg64_shift_reg: WIDTH-bit parallel-load shift register, zero fill.
// Latency: load or shift takes effect on the next rising clk; ser_bit_o is a flop.
// Backpressure: holds its contents whenever neither load_i nor shift_en_i is set.
// Ports: clk, reset (async active-low clear), load_i/load_data_i, shift_en_i,
//        ser_bit_o (bit at the output end of the register).
module reg64_shift_reg
  import reg64_pkg::*;
#(
  parameter int WIDTH     = REG64_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_en_i,
  output logic             ser_bit_o
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  // Load wins over shift; the top never asserts both in the same cycle.
  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = load_data_i;
    end else if (shift_en_i) begin
      if (MSB_FIRST != 0) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      else                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) shreg_q <= '0;
    else        shreg_q <= shreg_d;
  end

  // Output taken straight from the register, so ser_out has no comb input path.
  assign ser_bit_o = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule

// File: rtl/reg64_serializer.sv
// reg64_serializer: serializes a WIDTH-bit word one bit per accepted beat.
// Latency: first bit valid the cycle after the load; word period >= WIDTH+1 cycles.
// Backpressure: ser_ready=0 freezes ser_out/ser_last/bit count; load_ready=0 while shifting.
// Ports: clk, reset (async active-low), bus (slave modport: load_* in, ser_*/busy out).
module reg64_serializer
  import reg64_pkg::*;
#(
  parameter int WIDTH     = REG64_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic               clk,
  input  logic               reset,
  reg64_serializer_if.slave  bus
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             load_ready_q, load_ready_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_last_q, ser_last_d;
  logic             busy_q, busy_d;

  logic load_fire;
  logic shift_fire;

  // load_valid only matters in IDLE; in SHIFT it is ignored entirely.
  assign load_fire  = (state_q == IDLE)  && bus.load_valid;
  assign shift_fire = (state_q == SHIFT) && bus.ser_ready;

  // Flags are computed for the next state so every output is a flop.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    load_ready_d = load_ready_q;
    ser_valid_d  = ser_valid_q;
    ser_last_d   = ser_last_q;
    busy_d       = busy_q;
    if (state_q == IDLE) begin
      if (bus.load_valid) begin
        state_d      = SHIFT;
        bit_cnt_d    = '0;
        load_ready_d = 1'b0;
        ser_valid_d  = 1'b1;
        ser_last_d   = (LAST_CNT == '0);
        busy_d       = 1'b1;
      end
    end else begin
      if (bus.ser_ready) begin
        if (bit_cnt_q == LAST_CNT) begin
          // Final bit accepted: counter parks at 0 instead of wrapping.
          state_d      = IDLE;
          bit_cnt_d    = '0;
          load_ready_d = 1'b1;
          ser_valid_d  = 1'b0;
          ser_last_d   = 1'b0;
          busy_d       = 1'b0;
        end else begin
          bit_cnt_d  = bit_cnt_q + CNT_ONE;
          ser_last_d = ((bit_cnt_q + CNT_ONE) == LAST_CNT);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      load_ready_q <= 1'b1;
      ser_valid_q  <= 1'b0;
      ser_last_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      load_ready_q <= load_ready_d;
      ser_valid_q  <= ser_valid_d;
      ser_last_q   <= ser_last_d;
      busy_q       <= busy_d;
    end
  end

  reg64_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load_fire),
    .load_data_i (bus.load_data),
    .shift_en_i  (shift_fire),
    .ser_bit_o   (bus.ser_out)
  );

  assign bus.load_ready = load_ready_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.ser_last   = ser_last_q;
  assign bus.busy       = busy_q;

endmodule

// File: doc/reg64_serializer.md
REG64_SERIALIZER -- requirements
Module: reg64_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning the parallel word width in bits.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, meaning 1 = bit WIDTH-1 is sent first and 0 = bit 0 is sent first.
REQ-003 Port clk: input, 1 bit, rising-edge clock.
REQ-004 Port reset: input, 1 bit, asynchronous, active-low reset.
REQ-005 Port load_data: input, WIDTH bits, parallel word to serialize.
REQ-006 Port load_valid: input, 1 bit, load_data is valid.
REQ-007 Port load_ready: output, 1 bit, block can accept a word.
REQ-008 Port ser_out: output, 1 bit, current serial bit.
REQ-009 Port ser_valid: output, 1 bit, ser_out is valid.
REQ-010 Port ser_ready: input, 1 bit, downstream accepts ser_out this cycle.
REQ-011 Port ser_last: output, 1 bit, ser_out is the final bit of the word.
REQ-012 Port busy: output, 1 bit, a word is in flight.

Function
REQ-013 The FSM SHALL have two states: IDLE and SHIFT.
REQ-014 In IDLE: load_ready=1, ser_valid=0, busy=0.
REQ-015 In IDLE, a load (load_valid && load_ready) SHALL capture load_data into the shift register, clear bit_cnt to 0, and enter SHIFT on the next cycle.
REQ-016 In SHIFT: load_ready=0, ser_valid=1, busy=1; load_valid SHALL be ignored.
REQ-017 ser_out SHALL be shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0].
REQ-018 The transfer rule SHALL be: a bit is accepted when ser_valid && ser_ready.
REQ-019 On accept: shift by one toward the output end (zero fill) and increment bit_cnt.
REQ-020 With ser_ready=0, ser_out, ser_last and bit_cnt SHALL hold unchanged (backpressure, no bit lost or duplicated).
REQ-021 ser_last SHALL equal (state==SHIFT && bit_cnt==WIDTH-1).
REQ-022 Accept while ser_last=1 SHALL return to IDLE on the next cycle; load_ready rises that cycle.
REQ-023 Minimum word period SHALL be WIDTH+1 cycles (1 load cycle + WIDTH shift cycles); no overlap of load and last bit.
REQ-024 bit_cnt SHALL be $clog2(WIDTH) bits wide and SHALL never wrap past WIDTH-1.
REQ-025 All outputs SHALL be driven from registered state only; there is no combinational path from load_* to ser_*.
REQ-026 A load_valid held high across a completed word SHALL start the next word on the first IDLE cycle.

Reset
REQ-027 reset=0 SHALL, asynchronously, force state=IDLE, shreg=0, bit_cnt=0.
REQ-028 Output values under reset SHALL be: load_ready=1, ser_valid=0, ser_out=0, ser_last=0, busy=0.
REQ-029 Reset asserted mid-SHIFT SHALL abort the word without any further ser_valid pulse; the partial word is discarded.
REQ-030 The first load SHALL be accepted no earlier than the first rising clk after reset deasserts.

Structure
REQ-031 A package reg64_pkg SHALL hold: the WIDTH default constant, the state enum type (IDLE, SHIFT), and the counter width constant.
REQ-032 One sub-module, reg64_shift_reg, SHALL hold the WIDTH-bit register with async active-low clear, load, and shift-enable.
REQ-033 The FSM and bit counter SHALL live in the top-level module.

Verification
REQ-034 Scenario: load 64'h8000_0000_0000_0001, ser_ready=1, MSB_FIRST=1 -> the bench sees 1, 62 zeros, then 1; ser_last only on bit 64; load_ready high 65 cycles after the load.
REQ-035 Scenario: load 64'hA5A5_A5A5_A5A5_A5A5 with ser_ready toggling every cycle -> 64 accepted bits equal to the word, 128 shift cycles, no duplicates.
REQ-036 Scenario: MSB_FIRST=0, load 64'h0000_0000_0000_0003 -> first two bits are 1, the remaining 62 are 0.
REQ-037 Scenario: load_valid held high with two words 64'h1 and 64'h2 back-to-back -> second load occurs 65 cycles after the first; 128 bits are correct.
REQ-038 Scenario: reset pulsed low after 20 bits of 64'hFFFF_FFFF_FFFF_FFFF -> ser_valid drops immediately, outputs match reset values, and the next load serializes cleanly.
REQ-039 Scenario: load_valid pulsed during SHIFT with 64'hDEAD -> ignored; the in-flight word is unchanged.
